// File: rtl/ppu_timing.sv
// ---------------------------------------------------------------------------
// ppu_timing
//
// Dot/line timing engine for the PPU. It counts dots within a scanline (lx)
// and scanlines within a frame (ly). From those registered counters it
// derives the following, all combinationally:
//   - the PPU mode: 0 HBlank, 1 VBlank, 2 OAM scan, 3 draw
//   - the LY==LYC coincidence flag
//   - the STAT, VBlank and frame-start pulses
//
// Parameters
//   DOTS_PER_LINE    dots per scanline (4..1024)
//   LINES_PER_FRAME  lines per frame, VBlank lines included (2..256)
//   VISIBLE_LINES    lines 0..VISIBLE_LINES-1 are drawn (< LINES_PER_FRAME)
//   OAM_DOTS         length of mode 2 in dots
//   DRAW_DOTS        length of mode 3 in dots
//                    (OAM_DOTS + DRAW_DOTS < DOTS_PER_LINE)
//
// Ports
//   clk_i          dot clock
//   rst_i          synchronous active-high reset; has priority over ena_i
//   ena_i          LCD enable (lcdc.ena); while low, counters are held at 0
//   lyc_i[7:0]     LY compare value
//   stat_ie_i[3:0] STAT source enables: [0] HBlank, [1] VBlank,
//                  [2] OAM, [3] LYC
//   lx_o           dot counter within the current line
//   ly_o[7:0]      current line
//   mode_o[1:0]    current PPU mode
//   lyc_match_o    ena & (LY == LYC)
//   stat_irq_o     one-cycle pulse on a rising edge of the combined STAT line
//   vblank_irq_o   one-cycle pulse at lx=0, ly=VISIBLE_LINES
//   frame_start_o  one-cycle pulse at lx=0, ly=0
//
// Configuration macro
//   PPU_TIMING_LYC_EN  When defined, the LYC compare is built.
//                      When undefined, lyc_match_o is tied to 0, lyc_i is
//                      ignored and stat_ie_i[3] has no effect.
// ---------------------------------------------------------------------------
`default_nettype none

module ppu_timing #(
    parameter int DOTS_PER_LINE   = 456,
    parameter int LINES_PER_FRAME = 154,
    parameter int VISIBLE_LINES   = 144,
    parameter int OAM_DOTS        = 80,
    parameter int DRAW_DOTS       = 172
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             ena_i,
    input  logic [7:0]                       lyc_i,
    input  logic [3:0]                       stat_ie_i,
    output logic [$clog2(DOTS_PER_LINE)-1:0] lx_o,
    output logic [7:0]                       ly_o,
    output logic [1:0]                       mode_o,
    output logic                             lyc_match_o,
    output logic                             stat_irq_o,
    output logic                             vblank_irq_o,
    output logic                             frame_start_o
);

    localparam int LXW = $clog2(DOTS_PER_LINE);

    // Terminal and boundary values, sized to the counters they are compared to.
    localparam logic [LXW-1:0] LX_LAST  = LXW'(DOTS_PER_LINE - 1);
    localparam logic [LXW-1:0] OAM_END  = LXW'(OAM_DOTS);
    localparam logic [LXW-1:0] DRAW_END = LXW'(OAM_DOTS + DRAW_DOTS);
    localparam logic [LXW-1:0] LX_ONE   = LXW'(1);
    localparam logic [7:0]     LY_LAST  = 8'(LINES_PER_FRAME - 1);
    localparam logic [7:0]     VIS_LINE = 8'(VISIBLE_LINES);

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_DRAW   = 2'd3
    } mode_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [LXW-1:0] lx_q, lx_d;
    logic [7:0]     ly_q, ly_d;
    logic           stat_line_q, stat_line_d;

    // -----------------------------------------------------------------------
    // Combinational decode of the registered counters
    // -----------------------------------------------------------------------
    mode_e mode;
    logic  lx_last;
    logic  ly_last;
    logic  lx_zero;
    logic  lyc_match;
    logic  lyc_src;
    logic  stat_line;

    assign lx_last = (lx_q == LX_LAST);
    assign ly_last = (ly_q == LY_LAST);
    assign lx_zero = (lx_q == '0);

    // The mode is never stored. It is decoded from lx/ly every cycle, so
    // it cannot drift from the counters. It also drops to HBlank at once
    // when the LCD is switched off.
    always_comb begin
        mode = MODE_HBLANK;
        if (!ena_i) begin
            mode = MODE_HBLANK;
        end else if (ly_q >= VIS_LINE) begin
            mode = MODE_VBLANK;
        end else if (lx_q < OAM_END) begin
            mode = MODE_OAM;
        end else if (lx_q < DRAW_END) begin
            mode = MODE_DRAW;
        end else begin
            mode = MODE_HBLANK;
        end
    end

`ifdef PPU_TIMING_LYC_EN
    // The compare uses the live lyc_i. A CPU write to LYC therefore shows
    // up in the same cycle, with no register stage in between.
    assign lyc_match = ena_i & (ly_q == lyc_i);
    assign lyc_src   = stat_ie_i[3] & lyc_match;
`else
    // Without the LYC feature, lyc_i and stat_ie_i[3] are deliberately
    // left unconnected to any logic.
    logic unused_lyc;
    assign unused_lyc = ^{lyc_i, stat_ie_i[3]};
    assign lyc_match  = 1'b0;
    assign lyc_src    = 1'b0;
`endif

    // The STAT sources are ORed into one level signal. An interrupt is
    // raised only on its rising edge. When one source hands over to
    // another while the line stays high, no second pulse is produced.
    // For example, HBlank of line N flows straight into OAM of line N+1.
    assign stat_line = ena_i & ((stat_ie_i[0] & (mode == MODE_HBLANK)) |
                                (stat_ie_i[1] & (mode == MODE_VBLANK)) |
                                (stat_ie_i[2] & (mode == MODE_OAM))    |
                                lyc_src);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        lx_d        = lx_q;
        ly_d        = ly_q;
        stat_line_d = stat_line_q;
        if (!ena_i) begin
            // LCD off: nothing of a partial frame is kept. The next enable
            // starts cleanly at the top of a frame.
            lx_d        = '0;
            ly_d        = '0;
            stat_line_d = 1'b0;
        end else begin
            stat_line_d = stat_line;
            if (lx_last) begin
                lx_d = '0;
                if (ly_last) begin
                    ly_d = '0;
                end else begin
                    ly_d = ly_q + 8'd1;
                end
            end else begin
                lx_d = lx_q + LX_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lx_q        <= '0;
            ly_q        <= '0;
            stat_line_q <= 1'b0;
        end else begin
            lx_q        <= lx_d;
            ly_q        <= ly_d;
            stat_line_q <= stat_line_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The pulses are masked while rst_i is high, so nothing fires during
    // the reset cycle itself. Without the mask, a frame_start could fire
    // if reset is asserted with ena_i high and the counters already at 0.
    assign lx_o          = lx_q;
    assign ly_o          = ly_q;
    assign mode_o        = mode;
    assign lyc_match_o   = lyc_match;
    assign stat_irq_o    = stat_line & ~stat_line_q & ~rst_i;
    assign vblank_irq_o  = ena_i & lx_zero & (ly_q == VIS_LINE) & ~rst_i;
    assign frame_start_o = ena_i & lx_zero & (ly_q == 8'd0) & ~rst_i;

endmodule

`default_nettype wire

// File: tb/tb_ppu_timing.sv
// ---------------------------------------------------------------------------
// tb_ppu_timing
//
// Two instances share one set of inputs:
//   u_dflt   default geometry (456 x 154)
//   u_small  small geometry (20 x 6, 4 visible, OAM 4, draw 8)
//
// Each cycle, every output is compared with a reference model. The model
// derives lx/ly from a single count of consecutive enabled cycles (t):
//   lx = t mod DOTS
//   ly = (t div DOTS) mod LINES
// Mode and pulses follow from those values. Directed checks cover the
// line/frame boundaries, LYC, enable drop and reset.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ppu_timing;

    localparam int DOTS [2] = '{456, 20};
    localparam int LINES[2] = '{154, 6};
    localparam int VIS  [2] = '{144, 4};
    localparam int OAM  [2] = '{80, 4};
    localparam int DRAW [2] = '{172, 8};

`ifdef PPU_TIMING_LYC_EN
    localparam bit LYC_ON = 1'b1;
`else
    localparam bit LYC_ON = 1'b0;
`endif

    // ---------------- clock / reset / stimulus signals ----------------
    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] lyc;
    logic [3:0] stat_ie;

    logic [8:0] lx0;
    logic [7:0] ly0;
    logic [1:0] mode0;
    logic       lm0, si0, vi0, fs0;

    logic [4:0] lx1;
    logic [7:0] ly1;
    logic [1:0] mode1;
    logic       lm1, si1, vi1, fs1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ppu_timing u_dflt (
        .clk_i         (clk),
        .rst_i         (rst),
        .ena_i         (ena),
        .lyc_i         (lyc),
        .stat_ie_i     (stat_ie),
        .lx_o          (lx0),
        .ly_o          (ly0),
        .mode_o        (mode0),
        .lyc_match_o   (lm0),
        .stat_irq_o    (si0),
        .vblank_irq_o  (vi0),
        .frame_start_o (fs0)
    );

    ppu_timing #(
        .DOTS_PER_LINE   (20),
        .LINES_PER_FRAME (6),
        .VISIBLE_LINES   (4),
        .OAM_DOTS        (4),
        .DRAW_DOTS       (8)
    ) u_small (
        .clk_i         (clk),
        .rst_i         (rst),
        .ena_i         (ena),
        .lyc_i         (lyc),
        .stat_ie_i     (stat_ie),
        .lx_o          (lx1),
        .ly_o          (ly1),
        .mode_o        (mode1),
        .lyc_match_o   (lm1),
        .stat_irq_o    (si1),
        .vblank_irq_o  (vi1),
        .frame_start_o (fs1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_t   [2];
    bit m_prev[2];
    bit m_line[2];

    // Packed output word: {8'b0, fs, vi, si, lm, mode[1:0], ly[7:0], lx[9:0]}
    function automatic logic [31:0] pack(input int lx, input int ly, input int md,
                                         input bit lm, input bit si, input bit vi, input bit fs);
        logic [9:0] plx;
        logic [7:0] ply;
        logic [1:0] pmd;
        plx = 10'(lx);
        ply = 8'(ly);
        pmd = 2'(md);
        return {8'd0, fs, vi, si, lm, pmd, ply, plx};
    endfunction

    function automatic logic [31:0] model_eval(input int d, input bit r, input bit en,
                                               input logic [7:0] lc, input logic [3:0] ie,
                                               input int t, input bit prev, output bit line);
        int lx, ly, md;
        bit lm, si, vi, fs;
        lx = t % DOTS[d];
        ly = (t / DOTS[d]) % LINES[d];
        if (!en)                          md = 0;
        else if (ly >= VIS[d])            md = 1;
        else if (lx < OAM[d])             md = 2;
        else if (lx < OAM[d] + DRAW[d])   md = 3;
        else                              md = 0;
        lm   = LYC_ON && en && (ly == int'(lc));
        line = en && ((ie[0] && md == 0) || (ie[1] && md == 1) ||
                      (ie[2] && md == 2) || (ie[3] && lm));
        si   = line && !prev && !r;
        vi   = en && lx == 0 && ly == VIS[d] && !r;
        fs   = en && lx == 0 && ly == 0 && !r;
        return pack(lx, ly, md, lm, si, vi, fs);
    endfunction

    // Event counters for the directed checks
    int cnt_stat0, cnt_vb0, cnt_fs0, cnt_lm0;

    // ---------------- driver tasks ----------------
    // sample: at the negedge, compare both DUTs against the model
    task automatic sample();
        logic [31:0] e0, e1;
        bit l0, l1;
        @(negedge clk);
        e0 = model_eval(0, rst, ena, lyc, stat_ie, m_t[0], m_prev[0], l0);
        e1 = model_eval(1, rst, ena, lyc, stat_ie, m_t[1], m_prev[1], l1);
        m_line[0] = l0;
        m_line[1] = l1;
        check_eq("dflt", pack(int'(lx0), int'(ly0), int'(mode0), lm0, si0, vi0, fs0), e0);
        check_eq("small", pack(int'(lx1), int'(ly1), int'(mode1), lm1, si1, vi1, fs1), e1);
        cnt_stat0 += int'(si0);
        cnt_vb0   += int'(vi0);
        cnt_fs0   += int'(fs0);
        cnt_lm0   += int'(lm0);
    endtask

    // advance: clock edge, update the model, settle 1 time unit
    task automatic advance();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst || !ena) begin
                m_t[d]    = 0;
                m_prev[d] = 1'b0;
            end else begin
                m_prev[d] = m_line[d];
                m_t[d]    = (m_t[d] + 1) % (DOTS[d] * LINES[d]);
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    // Advance until the default DUT shows the given position (bounded)
    task automatic seek(input int ly_t, input int lx_t, input string tag);
        for (int i = 0; i < 80000; i++) begin
            if (int'(ly0) == ly_t && int'(lx0) == lx_t) break;
            sample();
            advance();
        end
        check_eq(tag, {ly0, 15'd0, lx0}, {8'(ly_t), 15'd0, 9'(lx_t)});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int m2, m3, m0, s2, s3, s0;
        int first_vb1, last_fs1, period1;
        int stat_f, vb_f, fs_f, lm_f;

        rst     = 1'b1;
        ena     = 1'b0;
        lyc     = 8'd10;
        stat_ie = 4'b0101;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            m_t[d]    = 0;
            m_prev[d] = 1'b0;
        end

        // Reset state
        sample();
        check_eq("rst_lx", 32'(lx0), 32'd0);
        check_eq("rst_ly", 32'(ly0), 32'd0);
        check_eq("rst_mode", 32'(mode0), 32'd0);
        check_eq("rst_pulses", {29'd0, si0, vi0, fs0}, 32'd0);
        advance();
        rst = 1'b0;
        run(3);

        // Line timing and one full frame, STAT on HBlank + OAM
        cnt_stat0 = 0; cnt_vb0 = 0; cnt_fs0 = 0; cnt_lm0 = 0;
        m2 = 0; m3 = 0; m0 = 0; s2 = 0; s3 = 0; s0 = 0;
        first_vb1 = -1; last_fs1 = -1; period1 = -1;
        ena = 1'b1;
        for (int i = 0; i < 456 * 154; i++) begin
            sample();
            if (i == 0) begin
                check_eq("en_frame_start", 32'(fs0), 32'd1);
                check_eq("en_mode", 32'(mode0), 32'd2);
                check_eq("en_stat_oam", 32'(si0), 32'd1);
            end
            if (i < 456) begin
                if (mode0 == 2'd2) m2++;
                if (mode0 == 2'd3) m3++;
                if (mode0 == 2'd0) m0++;
            end
            if (i < 20) begin
                if (mode1 == 2'd2) s2++;
                if (mode1 == 2'd3) s3++;
                if (mode1 == 2'd0) s0++;
            end
            if (i == 456) begin
                check_eq("line1_ly", 32'(ly0), 32'd1);
                check_eq("line1_lx", 32'(lx0), 32'd0);
            end
            if (i == 144 * 456) check_eq("vblank_mode", 32'(mode0), 32'd1);
            if (i == 456 * 154 - 1) check_eq("last_line_ly", 32'(ly0), 32'd153);
            if (vi1 && first_vb1 < 0) first_vb1 = i;
            if (fs1) begin
                if (last_fs1 >= 0 && period1 < 0) period1 = i - last_fs1;
                last_fs1 = i;
            end
            advance();
        end
        stat_f = cnt_stat0; vb_f = cnt_vb0; fs_f = cnt_fs0; lm_f = cnt_lm0;

        // Frame wrap: both counters return to 0 on the same edge
        sample();
        check_eq("wrap_lx", 32'(lx0), 32'd0);
        check_eq("wrap_ly", 32'(ly0), 32'd0);
        check_eq("wrap_frame_start", 32'(fs0), 32'd1);
        check_eq("wrap_mode", 32'(mode0), 32'd2);
        advance();

        check_eq("line0_mode2_dots", m2, 32'd80);
        check_eq("line0_mode3_dots", m3, 32'd172);
        check_eq("line0_mode0_dots", m0, 32'd204);
        check_eq("frame_vblank_irqs", vb_f, 32'd1);
        check_eq("frame_starts", fs_f, 32'd1);
        // One pulse at enable. Then one per visible line at the entry to
        // HBlank. The HBlank-to-OAM handover keeps the line high, so there
        // is no pulse at lx=0 of lines 1..143.
        check_eq("frame_stat_irqs", stat_f, 32'd145);
        check_eq("frame_lyc_cycles", lm_f, LYC_ON ? 32'd456 : 32'd0);
        check_eq("small_mode2_dots", s2, 32'd4);
        check_eq("small_mode3_dots", s3, 32'd8);
        check_eq("small_mode0_dots", s0, 32'd8);
        check_eq("small_first_vblank", first_vb1, 32'd80);
        check_eq("small_frame_period", period1, 32'd120);

        // LYC as the only STAT source
        stat_ie   = 4'b1000;
        cnt_stat0 = 0;
        seek(12, 100, "seek_lyc");
        check_eq("lyc_stat_irqs", cnt_stat0, LYC_ON ? 32'd1 : 32'd0);
        lyc = 8'd12;
        sample();
        check_eq("lyc_same_cycle", 32'(lm0), LYC_ON ? 32'd1 : 32'd0);
        check_eq("lyc_write_irq", 32'(si0), LYC_ON ? 32'd1 : 32'd0);
        advance();
        lyc = 8'd10;

        // Drop enable mid-line
        seek(12, 200, "seek_drop");
        ena = 1'b0;
        sample();
        check_eq("drop_mode_now", 32'(mode0), 32'd0);
        advance();
        sample();
        check_eq("drop_lx", 32'(lx0), 32'd0);
        check_eq("drop_ly", 32'(ly0), 32'd0);
        check_eq("drop_mode", 32'(mode0), 32'd0);
        advance();
        ena = 1'b1;
        sample();
        check_eq("reen_frame_start", 32'(fs0), 32'd1);
        check_eq("reen_mode", 32'(mode0), 32'd2);
        advance();
        run(300);

        // Reset while enabled
        rst = 1'b1;
        sample();
        check_eq("rst_mid_pulses", {29'd0, si0, vi0, fs0}, 32'd0);
        advance();
        rst = 1'b0;
        sample();
        check_eq("rst_mid_lx", 32'(lx0), 32'd0);
        check_eq("rst_mid_ly", 32'(ly0), 32'd0);
        advance();

        // Randomised phase: enable drops, resets, STAT enables, LYC values
        for (int i = 0; i < 8000; i++) begin
            ena = ($urandom_range(0, 299) != 0);
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 63) == 0) stat_ie = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) lyc = 8'($urandom_range(0, 7));
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the sequence is roughly 85k cycles long
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
